// File: rtl/timebase_generator.sv
// System timebase: derives single-cycle microsecond, millisecond and second strobes
// from clk, plus a seconds uptime counter, after a startup hold that gates ready.
`timescale 1ns/1ps

// state   | meaning
// STARTUP | counting the hold after reset; ticks quiet, en/clr ignored
// RUN     | prescaler cascade advancing while en=1
// PAUSE   | en was low: counters and uptime frozen, ticks quiet
module timebase_generator #(
   parameter int CLK_FREQUENCY = 10_000_000,
   parameter int US_PER_MS     = 1000,
   parameter int MS_PER_S      = 1000,
   parameter int STARTUP_US    = 100
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        en,
   input  logic        clr,
   output logic        ready,
   output logic        tick_us,
   output logic        tick_ms,
   output logic        tick_s,
   output logic [31:0] uptime_s
);

   localparam int US_DIV      = CLK_FREQUENCY / 1_000_000;
   localparam int STARTUP_CYC = STARTUP_US * US_DIV;
   localparam int PS_W = (US_DIV    > 1) ? $clog2(US_DIV)    : 1;
   localparam int US_W = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
   localparam int MS_W = (MS_PER_S  > 1) ? $clog2(MS_PER_S)  : 1;
   localparam int ST_W = (STARTUP_CYC > 0) ? $clog2(STARTUP_CYC + 1) : 1;

   typedef enum logic [1:0] {
      ST_STARTUP = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [ST_W-1:0] st_cnt;
   logic [PS_W-1:0] ps_cnt;
   logic [US_W-1:0] us_cnt;
   logic [MS_W-1:0] ms_cnt;

   logic st_done;
   logic st_count;
   logic ready_set;
   logic cnt_clr;
   logic cnt_adv;
   logic ps_wrap;
   logic us_term;
   logic ms_term;

   assign st_done = (st_cnt == ST_W'(STARTUP_CYC));
   assign ps_wrap = (ps_cnt == PS_W'(US_DIV - 1));
   assign us_term = (us_cnt == US_W'(US_PER_MS - 1));
   assign ms_term = (ms_cnt == MS_W'(MS_PER_S - 1));

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= ST_STARTUP;
      end else begin
         state <= state_nxt;
      end
   end

   // clr holds the run/pause state, except that en=0 still forces PAUSE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_STARTUP: if (st_done)      state_nxt = ST_RUN;
         ST_RUN:     if (!en)          state_nxt = ST_PAUSE;
         ST_PAUSE:   if (en && !clr)   state_nxt = ST_RUN;
         default:                      state_nxt = ST_STARTUP;
      endcase
   end

   // The edge that samples en=1 in PAUSE already counts, so en acts as a pure
   // clock enable for the cascade once the hold is over.
   always_comb begin
      st_count  = 1'b0;
      ready_set = 1'b0;
      cnt_clr   = 1'b0;
      cnt_adv   = 1'b0;
      case (state)
         ST_STARTUP: begin
            st_count  = !st_done;
            ready_set = st_done;
         end
         ST_RUN, ST_PAUSE: begin
            cnt_clr = clr;
            cnt_adv = en && !clr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         st_cnt <= '0;
         ready  <= 1'b0;
      end else begin
         if (st_count) begin
            st_cnt <= st_cnt + 1'b1;
         end
         if (ready_set) begin
            ready <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ps_cnt   <= '0;
         us_cnt   <= '0;
         ms_cnt   <= '0;
         uptime_s <= '0;
         tick_us  <= 1'b0;
         tick_ms  <= 1'b0;
         tick_s   <= 1'b0;
      end else if (cnt_clr) begin
         ps_cnt   <= '0;
         us_cnt   <= '0;
         ms_cnt   <= '0;
         uptime_s <= '0;
         tick_us  <= 1'b0;
         tick_ms  <= 1'b0;
         tick_s   <= 1'b0;
      end else begin
         tick_us <= cnt_adv && ps_wrap;
         tick_ms <= cnt_adv && ps_wrap && us_term;
         tick_s  <= cnt_adv && ps_wrap && us_term && ms_term;
         if (cnt_adv) begin
            ps_cnt <= ps_wrap ? '0 : ps_cnt + 1'b1;
            if (ps_wrap) begin
               us_cnt <= us_term ? '0 : us_cnt + 1'b1;
               if (us_term) begin
                  ms_cnt <= ms_term ? '0 : ms_cnt + 1'b1;
                  if (ms_term) begin
                     uptime_s <= uptime_s + 32'd1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_timebase_generator.sv
// Directed bench for timebase_generator: default build for the startup hold and reset,
// a small cascade build (4 us/ms, 3 ms/s, no hold) for timing, pause, clear and wrap.
`timescale 1ns/1ps

module tb_timebase_generator;

   logic clk = 1'b0;
   always #50 clk = ~clk;

   logic        rstb_d = 1'b0, en_d = 1'b0, clr_d = 1'b0;
   logic        ready_d, tick_us_d, tick_ms_d, tick_s_d;
   logic [31:0] up_d;

   logic        rstb_s = 1'b0, en_s = 1'b0, clr_s = 1'b0;
   logic        ready_s, tick_us_s, tick_ms_s, tick_s_s;
   logic [31:0] up_s;

   int n_chk  = 0;
   int n_pass = 0;

   timebase_generator dut_def (
      .clk      (clk),
      .rstb     (rstb_d),
      .en       (en_d),
      .clr      (clr_d),
      .ready    (ready_d),
      .tick_us  (tick_us_d),
      .tick_ms  (tick_ms_d),
      .tick_s   (tick_s_d),
      .uptime_s (up_d)
   );

   timebase_generator #(
      .US_PER_MS  (4),
      .MS_PER_S   (3),
      .STARTUP_US (0)
   ) dut_sm (
      .clk      (clk),
      .rstb     (rstb_s),
      .en       (en_s),
      .clr      (clr_s),
      .ready    (ready_s),
      .tick_us  (tick_us_s),
      .tick_ms  (tick_ms_s),
      .tick_s   (tick_s_s),
      .uptime_s (up_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bad, e_us, e_ms, e_s, n_us;

      rstb_d = 1'b0; en_d = 1'b1; clr_d = 1'b0;
      rstb_s = 1'b0; en_s = 1'b1; clr_s = 1'b0;
      repeat (3) step();
      chk("rst_ready",   32'(ready_d),   0);
      chk("rst_tick_us", 32'(tick_us_d), 0);
      chk("rst_uptime",  up_d,           0);
      chk("rst_ready_s", 32'(ready_s),   0);

      // startup hold on the default build: ready after edge 1001, first tick 10 later
      rstb_d = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         bad += int'(tick_us_d | tick_ms_d | tick_s_d);
      end
      chk("startup_hold",  32'(ready_d), 0);
      chk("startup_quiet", bad,          0);
      step();
      chk("ready_rise", 32'(ready_d), 1);
      bad = 0;
      repeat (9) begin
         step();
         bad += int'(tick_us_d);
      end
      chk("first_tick_early", bad,            0);
      step();
      chk("first_tick_us",    32'(tick_us_d), 1);

      // cascade timing on the small build
      rstb_s = 1'b1;
      step();
      chk("sm_ready_edge1", 32'(ready_s), 1);
      e_us = 0; e_ms = 0; e_s = 0; n_us = 0;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (tick_us_s !== (c % 10 == 0))  e_us++;
         if (tick_ms_s !== (c % 40 == 0))  e_ms++;
         if (tick_s_s  !== (c % 120 == 0)) e_s++;
         n_us += int'(tick_us_s);
         if (c == 239) chk("uptime_239", up_s, 1);
         if (c == 240) chk("uptime_240", up_s, 2);
      end
      chk("cascade_us",   e_us, 0);
      chk("cascade_ms",   e_ms, 0);
      chk("cascade_s",    e_s,  0);
      chk("cascade_n_us", n_us, 30);

      // pause 57 cycles with the prescaler at 3
      n_us = 0; bad = 0;
      repeat (3) begin
         step();
         n_us += int'(tick_us_s);
      end
      en_s = 1'b0;
      repeat (57) begin
         step();
         bad  += int'(tick_us_s | tick_ms_s | tick_s_s);
         n_us += int'(tick_us_s);
      end
      chk("pause_quiet",  bad,  0);
      chk("pause_uptime", up_s, 2);
      en_s = 1'b1;
      bad = 0;
      for (int i = 1; i <= 67; i++) begin
         step();
         n_us += int'(tick_us_s);
         if (i < 7) bad += int'(tick_us_s);
         if (i == 7) chk("resume_tick", 32'(tick_us_s), 1);
      end
      chk("resume_early",   bad,  0);
      chk("pause_total_us", n_us, 7);

      // clear mid-period with uptime 5 (604 enabled cycles, prescaler at 4)
      repeat (234) step();
      chk("pre_clr_uptime", up_s, 5);
      clr_s = 1'b1;
      step();
      clr_s = 1'b0;
      chk("clr_uptime", up_s,           0);
      chk("clr_ready",  32'(ready_s),   1);
      chk("clr_tick",   32'(tick_us_s), 0);
      e_us = 0; e_ms = 0;
      for (int c = 1; c <= 120; c++) begin
         step();
         if (tick_us_s !== (c % 10 == 0)) e_us++;
         if (tick_ms_s !== (c % 40 == 0)) e_ms++;
      end
      chk("clr_us_phase",  e_us,           0);
      chk("clr_ms_phase",  e_ms,           0);
      chk("clr_tick_s",    32'(tick_s_s),  1);
      chk("clr_uptime_1s", up_s,           1);

      // uptime wrap
      force dut_sm.uptime_s = 32'hFFFF_FFFF;
      #1;
      release dut_sm.uptime_s;
      #1;
      chk("force_uptime", up_s, 32'hFFFF_FFFF);
      repeat (119) step();
      chk("wrap_pre",    up_s,          32'hFFFF_FFFF);
      chk("wrap_pre_ts", 32'(tick_s_s), 0);
      step();
      chk("wrap_tick_s", 32'(tick_s_s), 1);
      chk("wrap_uptime", up_s,          0);

      // asynchronous reset between edges, then a restart with clr high and en low
      chk("pre_reset_ready", 32'(ready_d), 1);
      rstb_d = 1'b0;
      #5;
      chk("async_ready",   32'(ready_d),   0);
      chk("async_tick_us", 32'(tick_us_d), 0);
      en_d  = 1'b0;
      clr_d = 1'b1;
      #10;
      rstb_d = 1'b1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         bad += int'(tick_us_d | tick_ms_d | tick_s_d);
      end
      chk("restart_hold",  32'(ready_d), 0);
      chk("restart_quiet", bad,          0);
      step();
      chk("restart_ready", 32'(ready_d), 1);
      en_d  = 1'b1;
      clr_d = 1'b0;
      bad = 0;
      repeat (9) begin
         step();
         bad += int'(tick_us_d);
      end
      chk("restart_tick_early", bad,            0);
      step();
      chk("restart_first_tick", 32'(tick_us_d), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
